// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_unit
// Description : RV32I data memory with byte/half/word loads and stores.
//               Stores are synchronous, loads are combinational.
//               Faulting accesses are flagged and the first one is captured.
// Revision    : 1.0
// ============================================================================
module data_memory_unit #(
  parameter int DEPTH_WORDS = 64,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr,
  input  logic [31:0]        write_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  output logic [31:0]        read_data,
  output logic               misaligned,
  output logic               out_of_range,
  output logic               fault_sticky,
  output logic [31:0]        fault_addr,
  output logic [COUNT_W-1:0] store_count
);

  localparam int          c_idx_w = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_limit = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  c_f3_b  = 3'b000;
  localparam logic [2:0]  c_f3_h  = 3'b001;
  localparam logic [2:0]  c_f3_w  = 3'b010;
  localparam logic [2:0]  c_f3_bu = 3'b100;
  localparam logic [2:0]  c_f3_hu = 3'b101;

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic               r_fault_sticky;
  logic [31:0]        r_fault_addr;
  logic [COUNT_W-1:0] r_store_count;

  logic [c_idx_w-1:0] w_idx;
  logic               w_active;
  logic               w_half;
  logic               w_word;
  logic               w_illegal;
  logic               w_fault;
  logic               w_commit;
  logic [31:0]        w_rd_word;
  logic [7:0]         w_byte;
  logic [15:0]        w_hword;
  logic [3:0]         w_be;
  logic [31:0]        w_wr_word;

  assign w_idx     = addr[c_idx_w+1:2];
  assign w_active  = mem_read | mem_write;
  assign w_half    = (funct3 == c_f3_h) | (funct3 == c_f3_hu);
  assign w_word    = (funct3 == c_f3_w);
  assign w_illegal = w_active & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111) |
                                 (mem_write & ((funct3 == c_f3_bu) | (funct3 == c_f3_hu))));

  // An illegal access is reported only through the fault path, never as misaligned/out-of-range.
  assign misaligned   = w_active & ~w_illegal &
                        ((w_half & addr[0]) | (w_word & (addr[1:0] != 2'b00)));
  assign out_of_range = w_active & ~w_illegal & ({1'b0, addr} >= c_limit);
  assign w_fault      = misaligned | out_of_range | w_illegal;
  assign w_commit     = mem_write & ~w_fault;

  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    case (addr[1:0])
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
    w_hword = addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
  end

  always_comb begin
    read_data = '0;
    if (mem_read && !w_fault) begin
      case (funct3)
        c_f3_b:  read_data = {{24{w_byte[7]}}, w_byte};
        c_f3_bu: read_data = {24'd0, w_byte};
        c_f3_h:  read_data = {{16{w_hword[15]}}, w_hword};
        c_f3_hu: read_data = {16'd0, w_hword};
        c_f3_w:  read_data = w_rd_word;
        default: read_data = '0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be      = 4'b0000;
    w_wr_word = write_data;
    case (funct3)
      c_f3_b: begin
        w_be      = 4'b0001 << addr[1:0];
        w_wr_word = {4{write_data[7:0]}};
      end
      c_f3_h: begin
        w_be      = addr[1] ? 4'b1100 : 4'b0011;
        w_wr_word = {2{write_data[15:0]}};
      end
      c_f3_w:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store_count <= '0;
    end else if (w_commit) begin
      r_store_count <= r_store_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_sticky <= 1'b0;
      r_fault_addr   <= '0;
    end else if (w_fault && !r_fault_sticky) begin
      r_fault_sticky <= 1'b1;
      r_fault_addr   <= addr;
    end
  end

  assign fault_sticky = r_fault_sticky;
  assign fault_addr   = r_fault_addr;
  assign store_count  = r_store_count;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_unit
// Description : Scoreboard bench for data_memory_unit loads, stores and faults.
// Revision    : 1.0
// ============================================================================
module tb_data_memory_unit;

  localparam int DEPTH_WORDS = 64;
  localparam int COUNT_W     = 4;
  localparam int SEL_RD      = 0;
  localparam int SEL_MIS     = 1;
  localparam int SEL_OOR     = 2;
  localparam int SEL_STICKY  = 3;
  localparam int SEL_FADDR   = 4;
  localparam int SEL_CNT     = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        addr = '0;
  logic [31:0]        write_data = '0;
  logic               mem_read = 1'b0;
  logic               mem_write = 1'b0;
  logic [2:0]         funct3 = '0;
  logic [31:0]        read_data;
  logic               misaligned;
  logic               out_of_range;
  logic               fault_sticky;
  logic [31:0]        fault_addr;
  logic [COUNT_W-1:0] store_count;

  data_memory_unit #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .read_data   (read_data),
    .misaligned  (misaligned),
    .out_of_range(out_of_range),
    .fault_sticky(fault_sticky),
    .fault_addr  (fault_addr),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD:     return read_data;
      SEL_MIS:    return 32'(misaligned);
      SEL_OOR:    return 32'(out_of_range);
      SEL_STICKY: return 32'(fault_sticky);
      SEL_FADDR:  return fault_addr;
      SEL_CNT:    return 32'(store_count);
      default:    return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    write_data = '0;
  endtask

  // One access per cycle: drive at the falling edge, compare 1 time unit later,
  // commit on the following rising edge.
  task automatic step(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd_exp,
                      input logic mis_exp, input logic oor_exp);
    @(negedge clk);
    mem_read   = mr;
    mem_write  = mw;
    funct3     = f3;
    addr       = a;
    write_data = wd;
    if (mr || !mw) push({tag, ".rd"}, SEL_RD, rd_exp);
    push({tag, ".mis"}, SEL_MIS, 32'(mis_exp));
    push({tag, ".oor"}, SEL_OOR, 32'(oor_exp));
    #1 drain();
  endtask

  task automatic regs(input string tag, input logic st, input logic [31:0] fa, input logic [31:0] cnt);
    push({tag, ".sticky"}, SEL_STICKY, 32'(st));
    push({tag, ".faddr"}, SEL_FADDR, fa);
    push({tag, ".count"}, SEL_CNT, cnt);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    regs("por", 1'b0, 32'h0, 32'd0);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h10;
    #1 push("por.rd", SEL_RD, 32'h0);
    drain();
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    step("sw10",   0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    regs("sw10", 1'b0, 32'h0, 32'd0);
    step("lw10",   1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    regs("lw10", 1'b0, 32'h0, 32'd1);

    step("sb11",   0, 1, 3'b000, 32'h11, 32'h000000F0, 32'h0, 0, 0);
    step("lw10b",  1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADF0EF, 0, 0);
    regs("lw10b", 1'b0, 32'h0, 32'd2);
    step("lb11",   1, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFF0, 0, 0);
    step("lbu11",  1, 0, 3'b100, 32'h11, 32'h0, 32'h000000F0, 0, 0);
    step("lh12",   1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
    step("lhu12",  1, 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0, 0);
    step("lh10",   1, 0, 3'b001, 32'h10, 32'h0, 32'hFFFFF0EF, 0, 0);

    step("sw20",   0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    step("sh21",   0, 1, 3'b001, 32'h21, 32'h00001234, 32'h0, 1, 0);
    regs("sh21", 1'b0, 32'h0, 32'd3);
    step("lw20",   1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);
    regs("lw20", 1'b1, 32'h21, 32'd3);
    step("lw22",   1, 0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 0);
    step("lb23",   1, 0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFCA, 0, 0);
    regs("lb23", 1'b1, 32'h21, 32'd3);

    step("swfc",   0, 1, 3'b010, 32'hFC, 32'h0BADF00D, 32'h0, 0, 0);
    step("lwfc",   1, 0, 3'b010, 32'hFC, 32'h0, 32'h0BADF00D, 0, 0);
    step("lw100",  1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 1);
    step("swtop",  0, 1, 3'b010, 32'hFFFFFFFC, 32'h55555555, 32'h0, 0, 1);
    step("lwfc2",  1, 0, 3'b010, 32'hFC, 32'h0, 32'h0BADF00D, 0, 0);
    regs("lwfc2", 1'b1, 32'h21, 32'd4);
    step("lhufe",  1, 0, 3'b101, 32'hFE, 32'h0, 32'h00000BAD, 0, 0);

    step("ill011", 1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 0, 0);
    step("illsbu", 0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 0);
    step("ill111", 1, 0, 3'b111, 32'h13, 32'h0, 32'h0, 0, 0);
    step("illshu", 0, 1, 3'b101, 32'h101, 32'hFFFFFFFF, 32'h0, 0, 0);
    step("lw10c",  1, 0, 3'b010, 32'h10, 32'h0, 32'hDEADF0EF, 0, 0);
    regs("lw10c", 1'b1, 32'h21, 32'd4);

    step("sw30",   0, 1, 3'b010, 32'h30, 32'h11111111, 32'h0, 0, 0);
    step("rdw30",  1, 1, 3'b010, 32'h30, 32'h22222222, 32'h11111111, 0, 0);
    regs("rdw30", 1'b1, 32'h21, 32'd5);
    step("lw30",   1, 0, 3'b010, 32'h30, 32'h0, 32'h22222222, 0, 0);
    regs("lw30", 1'b1, 32'h21, 32'd6);
    step("inact",  0, 0, 3'b010, 32'h11, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset between edges, with a store held across a reset edge.
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1 regs("arst", 1'b0, 32'h0, 32'd0);
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h10;
    #1 push("arst.rd", SEL_RD, 32'h0);
    drain();
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = 32'h40;
    write_data = 32'h77777777;
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    step("lw40",   1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0);
    regs("lw40", 1'b0, 32'h0, 32'd0);
    step("lw10r",  1, 0, 3'b010, 32'h10, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i <= 16; i++) begin
      step("wrap.sw", 0, 1, 3'b010, 32'h0, 32'(i), 32'h0, 0, 0);
      regs("wrap", 1'b0, 32'h0, 32'(i % 16));
    end
    step("wrap.lw", 1, 0, 3'b010, 32'h0, 32'h0, 32'd16, 0, 0);
    regs("wrap.end", 1'b0, 32'h0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
